// File: rtl/losc_ctl_ice.sv
// Low-speed (15 kHz WDT) oscillator controller: synchronises LOSCOUT, qualifies
// start-up, strobes WDT counts and flags a stalled oscillator.
module losc_ctl_ice #(
  parameter int unsigned STABLE_CNT = 8,
  parameter int unsigned TMO_CNT    = 4095,
  parameter int unsigned STOP_WAIT  = 4
) (
  input  logic CLK30MHZ,
  input  logic PONRESB,
  input  logic LOSCEN,
  input  logic FAILCLR,
  input  logic LOSCOUT,
  output logic LOSCSTPZ,
  output logic LOSCRDY,
  output logic LOSCEDGE,
  output logic LOSCFAIL
);

  localparam logic [7:0]  STABLE_V = 8'(STABLE_CNT);
  localparam logic [11:0] TMO_V    = 12'(TMO_CNT);
  localparam logic [3:0]  STOP_V   = 4'(STOP_WAIT);

  typedef enum logic [1:0] {OFF, START, RUN, STOP} state_t;

  state_t      state, state_next;
  logic        s1, s2, h;
  logic        rise;
  logic        tmo_expire;
  logic [7:0]  edge_cnt, edge_cnt_next;
  logic [11:0] tmo_cnt, tmo_cnt_next;
  logic [3:0]  stop_cnt, stop_cnt_next;
  logic        stpz_next, rdy_next, edge_next, fail_next;

  // LOSCOUT is asynchronous: two-flop synchroniser plus a history flop for edges
  always_ff @(posedge CLK30MHZ or negedge PONRESB) begin
    if (!PONRESB) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      h  <= 1'b0;
    end else begin
      s1 <= LOSCOUT;
      s2 <= s1;
      h  <= s2;
    end
  end

  assign rise = s2 & ~h;

  always_comb begin
    state_next    = state;
    edge_cnt_next = edge_cnt;
    tmo_cnt_next  = tmo_cnt;
    stop_cnt_next = stop_cnt;
    tmo_expire    = 1'b0;

    // Stall watchdog; a rise in the expiry cycle wins over the timeout
    if (state == START || state == RUN) begin
      if (rise) begin
        tmo_cnt_next = TMO_V;
      end else if (tmo_cnt <= 12'd1) begin
        tmo_expire   = 1'b1;
        tmo_cnt_next = TMO_V;
      end else begin
        tmo_cnt_next = tmo_cnt - 12'd1;
      end
    end

    case (state)
      OFF: begin
        if (LOSCEN) begin
          state_next    = START;
          edge_cnt_next = 8'd0;
          tmo_cnt_next  = TMO_V;
        end
      end
      START: begin
        if (!LOSCEN) begin
          state_next    = STOP;
          stop_cnt_next = STOP_V;
        end else if (rise) begin
          edge_cnt_next = edge_cnt + 8'd1;
          if (edge_cnt + 8'd1 == STABLE_V) state_next = RUN;
        end
      end
      RUN: begin
        if (!LOSCEN) begin
          state_next    = STOP;
          stop_cnt_next = STOP_V;
        end else if (tmo_expire) begin
          state_next    = START;
          edge_cnt_next = 8'd0;
        end
      end
      default: begin
        // Wait for the gated oscillator to be seen low long enough
        if (s2) begin
          stop_cnt_next = STOP_V;
        end else if (stop_cnt <= 4'd1) begin
          state_next = OFF;
        end else begin
          stop_cnt_next = stop_cnt - 4'd1;
        end
      end
    endcase

    stpz_next = (state_next == START) || (state_next == RUN);
    rdy_next  = (state_next == RUN);
    edge_next = (state == RUN) && rise;
    fail_next = tmo_expire ? 1'b1 : (FAILCLR ? 1'b0 : LOSCFAIL);
  end

  always_ff @(posedge CLK30MHZ or negedge PONRESB) begin
    if (!PONRESB) begin
      state    <= OFF;
      edge_cnt <= 8'd0;
      tmo_cnt  <= 12'd0;
      stop_cnt <= 4'd0;
      LOSCSTPZ <= 1'b0;
      LOSCRDY  <= 1'b0;
      LOSCEDGE <= 1'b0;
      LOSCFAIL <= 1'b0;
    end else begin
      state    <= state_next;
      edge_cnt <= edge_cnt_next;
      tmo_cnt  <= tmo_cnt_next;
      stop_cnt <= stop_cnt_next;
      LOSCSTPZ <= stpz_next;
      LOSCRDY  <= rdy_next;
      LOSCEDGE <= edge_next;
      LOSCFAIL <= fail_next;
    end
  end

endmodule

// File: tb/tb_losc_ctl_ice.sv
// Bench for losc_ctl_ice: randomized oscillator timing, behavioural reference
// model feeding a per-cycle expectation queue drained by an independent monitor.
module tb_losc_ctl_ice;

  localparam int STABLE = 8;
  localparam int TMO    = 4095;
  localparam int SW     = 4;
  localparam int M_OFF = 0, M_START = 1, M_RUN = 2, M_STOP = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b1;
  logic fclr = 1'b0;
  logic osc_raw = 1'b0;
  logic stpz, rdy, edg, fail;
  logic loscout;

  // The emulation macro gates its output with the run request
  assign loscout = osc_raw & stpz;

  always #16 clk = ~clk;

  losc_ctl_ice dut (
    .CLK30MHZ(clk),
    .PONRESB (rstn),
    .LOSCEN  (en),
    .FAILCLR (fclr),
    .LOSCOUT (loscout),
    .LOSCSTPZ(stpz),
    .LOSCRDY (rdy),
    .LOSCEDGE(edg),
    .LOSCFAIL(fail)
  );

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  // Reference model: mode plus "events seen" counts, per the behavioural rules
  int mode = M_OFF;
  int rises = 0;
  int quiet = 0;
  int lowrun = 0;
  int model_edges = 0;
  logic [2:0] hist = 3'b000;
  logic m_stpz = 1'b0, m_rdy = 1'b0, m_edge = 1'b0, m_fail = 1'b0;

  // Oscillator stimulus
  logic osc_on = 1'b1;
  int hmin = 3, hmax = 3, osc_left = 3;

  int dut_edges = 0;
  int mon_cyc = 0;

  task automatic summary_and_finish();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, need %0d", name, got, want);
    end
  endtask

  task automatic model_eval();
    logic lo, sync, rs, expire;
    lo = osc_raw & m_stpz;
    if (!rstn) begin
      mode = M_OFF; rises = 0; quiet = 0; lowrun = 0;
      hist = 3'b000; m_fail = 1'b0; m_edge = 1'b0;
    end else begin
      sync   = hist[1];
      rs     = hist[1] & ~hist[2];
      expire = 1'b0;
      m_edge = (mode == M_RUN) && rs;
      if (m_edge) model_edges++;
      if (mode == M_START || mode == M_RUN) begin
        if (rs) quiet = 0;
        else begin
          quiet++;
          if (quiet >= TMO) begin expire = 1'b1; quiet = 0; end
        end
      end
      case (mode)
        M_OFF:   if (en) begin mode = M_START; rises = 0; quiet = 0; end
        M_START: begin
          if (!en) begin mode = M_STOP; lowrun = 0; end
          else if (rs) begin rises++; if (rises == STABLE) mode = M_RUN; end
        end
        M_RUN: begin
          if (!en) begin mode = M_STOP; lowrun = 0; end
          else if (expire) begin mode = M_START; rises = 0; end
        end
        default: begin
          if (sync) lowrun = 0; else lowrun++;
          if (lowrun >= SW) mode = M_OFF;
        end
      endcase
      if (expire) m_fail = 1'b1;
      else if (fclr) m_fail = 1'b0;
      hist = {hist[1:0], lo};
    end
    m_stpz = (mode == M_START) || (mode == M_RUN);
    m_rdy  = (mode == M_RUN);
    exp_q.push_back({m_stpz, m_rdy, m_edge, m_fail});
  endtask

  task automatic osc_update();
    if (!osc_on) begin
      osc_raw = 1'b0;
    end else begin
      osc_left--;
      if (osc_left <= 0) begin
        osc_raw  = ~osc_raw;
        osc_left = $urandom_range(hmax, hmin);
      end
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge
  task automatic step();
    osc_update();
    model_eval();
    @(negedge clk);
  endtask

  task automatic run_to_mode(input int m, input int limit, input string name);
    int n = 0;
    while (mode != m && n < limit) begin step(); n++; end
    chk(name, mode, m);
  endtask

  // Monitor: pops the expectation for each clock and compares all outputs
  always begin
    logic [3:0] e, a;
    @(posedge clk);
    #1;
    mon_cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {stpz, rdy, edg, fail};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs cycle=%0d stpz/rdy/edge/fail got=%b need=%b", mon_cyc, a, e);
        if (bad >= 40) summary_and_finish();
      end
      if (edg) begin
        dut_edges++;
        $display("cycle=%0d LOSCEDGE strobe #%0d", mon_cyc, dut_edges);
      end
      if (a[3:2] != e[3:2] || a[0] != e[0]) ;
    end
  end

  always @(posedge rdy or negedge rdy or posedge fail or negedge fail) begin
    $display("time=%0t status rdy=%b fail=%b stpz=%b", $time, rdy, fail, stpz);
  end

  initial begin
    int e0, n, sc;
    @(negedge clk);
    // Reset held with LOSCEN=1 and a fast-toggling oscillator
    repeat (20) step();
    rstn = 1'b1;
    step();
    chk("stpz_after_release", int'(stpz), 1);

    // Nominal 2000-cycle oscillator with jitter
    hmin = 1010; hmax = 990; osc_left = 40;
    run_to_mode(M_RUN, 30000, "reach_run");
    chk("rdy_in_run", int'(rdy), 1);

    // Five periods in RUN
    e0 = dut_edges;
    n = model_edges;
    sc = 0;
    while (model_edges - n < 5 && sc < 15000) begin step(); sc++; end
    repeat (3) step();
    chk("run_edge_count", dut_edges - e0, 5);

    // Stall in RUN
    osc_on = 1'b0;
    sc = 0;
    while (!m_fail && sc < 5000) begin step(); sc++; end
    chk("stall_fail", int'(fail), 1);
    chk("stall_rdy", int'(rdy), 0);
    hmin = 250; hmax = 150; osc_left = 5; osc_on = 1'b1;
    run_to_mode(M_RUN, 10000, "recover_run");
    fclr = 1'b1; step(); fclr = 1'b0; step();
    chk("failclr", int'(fail), 0);

    // FAILCLR coincident with a new timeout
    osc_on = 1'b0;
    sc = 0;
    while (!(mode == M_RUN && quiet == TMO - 1) && sc < 5000) begin step(); sc++; end
    fclr = 1'b1; step(); fclr = 1'b0;
    chk("fail_set_wins", int'(fail), 1);
    chk("timeout_to_start", int'(rdy), 0);
    osc_on = 1'b1; osc_left = 3;

    // Drop LOSCEN in START after 3 rises, re-raise during STOP
    sc = 0;
    while (!(mode == M_START && rises == 3) && sc < 5000) begin step(); sc++; end
    repeat ($urandom_range(0, 100)) step();
    en = 1'b0; step();
    chk("drop_stpz", int'(stpz), 0);
    chk("drop_rdy", int'(rdy), 0);
    repeat ($urandom_range(1, 3)) step();
    en = 1'b1;
    sc = 0;
    while (mode != M_START && sc < 200) begin step(); sc++; end
    chk("stop_ignores_en", int'(sc >= 1), 1);
    chk("restart_stpz", int'(stpz), 1);

    // LOSCEN drop on the same cycle as the STABLE_CNT-th rise
    sc = 0;
    while (!(mode == M_START && rises == STABLE - 1 && hist[1] && !hist[2]) && sc < 10000) begin
      step(); sc++;
    end
    en = 1'b0; step();
    chk("last_rise_drop_rdy", int'(rdy), 0);
    chk("last_rise_drop_stpz", int'(stpz), 0);
    repeat (2) step();
    chk("last_rise_drop_rdy_late", int'(rdy), 0);
    en = 1'b1;
    run_to_mode(M_RUN, 10000, "rerun");

    // Asynchronous reset mid-RUN while the oscillator is high
    sc = 0;
    while (!(mode == M_RUN && osc_raw && hist[1]) && sc < 2000) begin step(); sc++; end
    #3 rstn = 1'b0;
    #1;
    chk("async_rst_stpz", int'(stpz), 0);
    chk("async_rst_rdy", int'(rdy), 0);
    chk("async_rst_edge", int'(edg), 0);
    chk("async_rst_fail", int'(fail), 0);
    repeat (5) step();
    rstn = 1'b1;
    e0 = dut_edges;
    repeat (60) step();
    chk("no_edge_after_reset", dut_edges - e0, 0);

    repeat (3) step();
    summary_and_finish();
  end

endmodule
